// File: rtl/hazard_scoreboard.sv
// Hazard detection and operand-forward select for the ID stage, backed by a falling-edge shift-register scoreboard.
// Outputs are combinational with zero latency; the scoreboard shifts on every falling edge, including while stalled.
module hazard_scoreboard #(
  parameter int DEPTH        = 3,
  parameter int RBITS        = 5,
  parameter int FWD_EN       = 1,
  parameter int LOAD_FWD_MIN = 1,
  parameter int CNT_W        = 16,
  parameter int SELW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwr,
  input  logic [RBITS-1:0] id_rw,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SELW-1:0]  fwd_a_sel,
  output logic [SELW-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            ld;
  logic [DEPTH-1:0][RBITS-1:0] rw;

  logic [1:0][RBITS-1:0] src;
  logic [1:0]            src_used;
  logic [1:0][SELW-1:0]  sel;
  logic [1:0]            src_haz;
  logic                  hazard;
  logic                  push;

  assign src      = {id_rt, id_rs};
  assign src_used = {id_uses_rt, id_uses_rs};

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel     = '0;
    src_haz = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (src_used[s] && (src[s] != '0) && v[k] && (rw[k] == src[s])) begin
          sel[s]     = SELW'(k + 1);
          src_haz[s] = (FWD_EN == 0) || (ld[k] && (k < LOAD_FWD_MIN));
        end
      end
    end
  end

  assign hazard    = src_haz[0] | src_haz[1];
  assign stall     = id_valid & hazard & ~flush;
  assign fwd_a_sel = (FWD_EN != 0) ? sel[0] : '0;
  assign fwd_b_sel = (FWD_EN != 0) ? sel[1] : '0;
  assign push      = id_valid & id_regwr & (id_rw != '0) & ~stall & ~flush;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      ld        <= '0;
      rw        <= '0;
      stall_cnt <= '0;
    end else begin
      v[0]  <= push;
      rw[0] <= id_rw;
      ld[0] <= id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        v[k]  <= v[k-1];
        rw[k] <= rw[k-1];
        ld[k] <= ld[k-1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, stall-only, flush, reset and saturation.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_regwr;
  logic [4:0] id_rw;
  logic       id_is_load;
  logic       flush;

  logic        f_stall, s_stall, t_stall, d_stall;
  logic [1:0]  f_a, f_b, s_a, s_b, t_a, t_b;
  logic [0:0]  d_a, d_b;
  logic [15:0] f_cnt, s_cnt, d_cnt;
  logic [3:0]  t_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_scoreboard u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_rw(id_rw),
    .id_is_load(id_is_load), .flush(flush), .stall(f_stall), .fwd_a_sel(f_a),
    .fwd_b_sel(f_b), .stall_cnt(f_cnt)
  );

  hazard_scoreboard #(.FWD_EN(0)) u_stl (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_rw(id_rw),
    .id_is_load(id_is_load), .flush(flush), .stall(s_stall), .fwd_a_sel(s_a),
    .fwd_b_sel(s_b), .stall_cnt(s_cnt)
  );

  hazard_scoreboard #(.FWD_EN(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_rw(id_rw),
    .id_is_load(id_is_load), .flush(flush), .stall(t_stall), .fwd_a_sel(t_a),
    .fwd_b_sel(t_b), .stall_cnt(t_cnt)
  );

  hazard_scoreboard #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_rw(id_rw),
    .id_is_load(id_is_load), .flush(flush), .stall(d_stall), .fwd_a_sel(d_a),
    .fwd_b_sel(d_b), .stall_cnt(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present one ID instruction; state advances on falling edges, so inputs change just after one.
  task automatic id(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                    input logic urt, input logic wr, input logic [4:0] rw, input logic lw,
                    input logic fl);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_regwr = wr; id_rw = rw; id_is_load = lw; flush = fl;
    #2;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", f_stall, 0);
    chk("rst_a", f_a, 0);
    chk("rst_b", f_b, 0);
    chk("rst_cnt", f_cnt, 0);
    step();
    rst_n = 1'b1;

    // Back-to-back dependents with repeated writers of $3.
    id(1, 1, 1, 2, 1, 1, 3, 0, 0);
    chk("fw0_stall", f_stall, 0);
    step();
    id(1, 3, 1, 4, 1, 1, 3, 0, 0);
    chk("fw1_stall", f_stall, 0);
    chk("fw1_a", f_a, 1);
    chk("fw1_b", f_b, 0);
    chk("d1_fw1_a", d_a, 1);
    step();
    id(1, 3, 1, 3, 1, 1, 10, 0, 0);
    chk("fw2_a_youngest", f_a, 1);
    chk("fw2_b_same_reg", f_b, 1);
    chk("d1_fw2_b", d_b, 1);
    step();
    id(1, 3, 1, 10, 1, 0, 0, 0, 0);
    chk("fw3_a", f_a, 2);
    chk("fw3_b", f_b, 1);
    chk("d1_fw3_a", d_a, 0);
    chk("d1_fw3_b", d_b, 1);
    step();
    chk("fw4_a", f_a, 3);
    chk("fw4_b", f_b, 2);
    step();
    chk("fw5_a", f_a, 0);
    chk("fw5_b", f_b, 3);
    step();

    // Load-use: one bubble, then forward from entry 1.
    do_reset();
    id(1, 1, 1, 0, 0, 1, 5, 1, 0);
    step();
    id(1, 1, 1, 5, 1, 1, 6, 0, 0);
    chk("lu_stall", f_stall, 1);
    chk("lu_cnt0", f_cnt, 0);
    step();
    chk("lu_stall2", f_stall, 0);
    chk("lu_b", f_b, 2);
    chk("lu_a", f_a, 0);
    chk("lu_cnt1", f_cnt, 1);
    step();
    chk("lu_cnt_after", f_cnt, 1);

    // Flush beats the load-use hazard and leaves a bubble.
    do_reset();
    id(1, 1, 1, 0, 0, 1, 5, 1, 0);
    step();
    id(1, 1, 1, 5, 1, 1, 6, 0, 1);
    chk("fl_stall", f_stall, 0);
    step();
    id(1, 1, 1, 5, 1, 1, 6, 0, 0);
    chk("fl_stall2", f_stall, 0);
    chk("fl_b", f_b, 2);
    chk("fl_cnt", f_cnt, 0);
    step();

    // Stall-only mode: three stall cycles until the writer retires.
    do_reset();
    id(1, 1, 1, 2, 1, 1, 7, 0, 0);
    step();
    id(1, 7, 1, 2, 1, 0, 0, 0, 0);
    chk("so_stall1", s_stall, 1);
    chk("so_a", s_a, 0);
    chk("so_b", s_b, 0);
    chk("so_fwd_alt_a", f_a, 1);
    step();
    chk("so_stall2", s_stall, 1);
    step();
    chk("so_stall3", s_stall, 1);
    chk("so_a3", s_a, 0);
    step();
    chk("so_stall4", s_stall, 0);
    chk("so_cnt", s_cnt, 3);
    step();

    // Register 0 and unused source never match.
    id(1, 1, 1, 2, 1, 1, 0, 0, 0);
    step();
    id(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("r0_stall", s_stall, 0);
    chk("r0_fa", f_a, 0);
    chk("r0_fb", f_b, 0);
    step();
    id(1, 1, 1, 2, 1, 1, 9, 0, 0);
    step();
    id(1, 1, 1, 9, 0, 0, 0, 0, 0);
    chk("nu_stall", s_stall, 0);
    chk("nu_fb", f_b, 0);
    step();

    // Self-dependent chain on $7: go, stall x3, repeating.
    do_reset();
    id(1, 7, 1, 2, 1, 1, 7, 0, 0);
    for (int i = 0; i < 7; i++) step();
    chk("ar_pre_stall", s_stall, 1);
    chk("ar_pre_cnt", s_cnt, 5);
    rst_n = 1'b0;
    #1;
    chk("ar_stall", s_stall, 0);
    chk("ar_cnt", s_cnt, 0);
    chk("ar_a", f_a, 0);
    chk("ar_b", f_b, 0);
    chk("ar_sat_cnt", t_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("sat_cnt40", t_cnt, 15);
    chk("wide_cnt40", s_cnt, 30);
    for (int i = 0; i < 4; i++) step();
    chk("sat_cnt44", t_cnt, 15);
    chk("wide_cnt44", s_cnt, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined CPU, superseding the fixed-depth stall logic. Tracks pending register writes for every stage between ID and WR in a shift-register scoreboard. Each cycle it tells the pipeline whether the instruction in ID must stall, and which stage, if any, feeds each ALU operand. Stall-only and forwarding modes are selectable by parameter, with a saturating stall-cycle counter for performance measurement.

## Interface
- DEPTH, 3: scoreboard entries; entry 0 = EX, entry DEPTH-1 = WR.
- RBITS, 5: register-specifier width.
- FWD_EN, 1: 1 = forwarding mode, 0 = stall-only mode.
- LOAD_FWD_MIN, 1: lowest entry index from which a load result may be forwarded.
- CNT_W, 16: stall counter width.
- SELW, $clog2(DEPTH+1): forward-select width (derived; not overridden).

Ports:
- clk  in  1  pipeline clock; all state advances on the falling edge, like the pipeline registers.
- rst_n  in  1  reset, asynchronous and active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  RBITS  ID source specifiers.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_regwr  in  1  ID instruction writes a register.
- id_rw  in  RBITS  ID destination specifier, RegDst already applied.
- id_is_load  in  1  ID instruction is lw.
- flush  in  1  taken branch; discard the ID instruction.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_a_sel, fwd_b_sel  out  SELW  0 = register file, k = result of entry k-1.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Each entry holds {v, rw, ld}. Register 0 is never tracked and never matches.
- Match for source src on entry k: src used, src != 0, v[k], rw[k] == src.
- Youngest match (lowest k) governs that source.
- FWD_EN=0: any match on rs or rt raises hazard. Both fwd selects are held at 0.
- FWD_EN=1, per source:
  - Youngest match with ld[k]=1 and k < LOAD_FWD_MIN raises hazard.
  - Otherwise, on a match, the select is k+1.
  - With no match, the select is 0.
- stall = id_valid & hazard & ~flush. The select outputs are valid only when stall=0.
- On each advance:
  - Entry k takes entry k-1 for k >= 1. The old entry DEPTH-1 retires.
  - Entry 0 takes {1, id_rw, id_is_load} when id_valid & id_regwr & id_rw != 0 & ~stall & ~flush; otherwise it takes a bubble (v=0).
  - Downstream entries keep shifting during a stall, so the hazard ages out.
- stall_cnt increments on each advance where stall=1 and saturates at all-ones.

## Timing
- stall, fwd_a_sel and fwd_b_sel are combinational from the ID inputs and registered state, settling within the same half-cycle. They have zero latency.
- Scoreboard update latency is one falling edge: an instruction leaving ID is visible in entry 0 from the next cycle.
- Reset, asynchronous, asserted at any time including mid-stall:
  - all v cleared and stall_cnt = 0;
  - consequently stall = 0 and both selects = 0 while rst_n = 0.
  - The first falling edge after deassertion performs a normal update.
- flush together with hazard: flush wins. stall=0, no bubble is counted, and entry 0 gets a bubble.
- Same register in rs and rt: both selects are computed identically.
- Multiple matches: the youngest wins. Older entries never override it.
- DEPTH=1 is legal. The select width is then 1 and the only nonzero select is 1.

## Test plan
- Back-to-back dependent add: $3 written, the next instruction reads rs=$3, FWD_EN=1. Required: stall=0, fwd_a_sel=1. One cycle later, with an unrelated instruction in between, the reader sees fwd_a_sel=2.
- Load-use: lw $5 then add reading rt=$5, LOAD_FWD_MIN=1. Required: stall=1 for exactly 1 cycle, stall_cnt 0->1. Next cycle: stall=0, fwd_b_sel=2.
- Stall-only mode, FWD_EN=0, DEPTH=3: writer of $7 followed by a reader of $7. Required: stall for 3 cycles, selects remain 0, stall_cnt=3.
- Register 0 and unused sources: a writer of $0, then a reader of $0; also id_uses_rt=0 with id_rt matching a pending write. Required: stall=0 and selects 0 in both cases.
- flush during load-use hazard: flush=1 in the hazard cycle. Required: stall=0, stall_cnt unchanged, entry 0 empty next cycle (a following reader of the load's rw sees the lw at fwd select 2 without a new stall).
- Async reset mid-stall: drop rst_n between edges while stall=1 and stall_cnt=5. Required: stall=0, stall_cnt=0, and selects 0 immediately, before any clock edge. Saturation check: CNT_W=4 under continuous stall holds at 15.
